// File: rtl/n2_com_dp_rf_param.sv
// rtl/n2_com_dp_rf_param.sv - parametrised 1W/1R register file with byte mask, valid/flush, bypass, parity
module n2_com_dp_rf_param #(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 152,
  parameter int AW     = 5,
  parameter int MASKW  = WIDTH / 8,
  parameter int RD_LAT = 1
) (
  input  logic             l2clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_adr,
  input  logic [MASKW-1:0] wr_mask,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_adr,
  input  logic             flush,
  input  logic             err_inject,
  input  logic             tcu_array_wr_inhibit,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             dout_miss,
  output logic [MASKW-1:0] dout_perr
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [MASKW-1:0] par_mem [DEPTH];
  logic [DEPTH-1:0] valid;

  logic             wr_eff;
  logic             rd_in_rng;
  logic             byp;
  logic             hit;
  logic [MASKW-1:0] wr_par;
  logic [WIDTH-1:0] rd_data;
  logic [MASKW-1:0] rd_par;
  logic [MASKW-1:0] rd_calc;

  logic [WIDTH-1:0] s0_data;
  logic             s0_miss;
  logic [MASKW-1:0] s0_perr;

  logic [WIDTH-1:0] s1_data;
  logic             s1_vld;
  logic             s1_miss;
  logic [MASKW-1:0] s1_perr;

  assign wr_eff    = wr_en & ~tcu_array_wr_inhibit & ({1'b0, wr_adr} < DEPTH_W);
  assign rd_in_rng = {1'b0, rd_adr} < DEPTH_W;
  assign byp       = wr_eff & (wr_adr == rd_adr);

  // Injection only lands when byte 0 is actually written, since unmasked bytes ignore wr_par.
  always_comb begin
    wr_par = '0;
    for (int i = 0; i < MASKW; i++) begin
      wr_par[i] = ^din[8*i +: 8];
    end
    wr_par[0] = wr_par[0] ^ err_inject;
  end

  always_ff @(posedge l2clk) begin
    if (wr_eff) begin
      for (int i = 0; i < MASKW; i++) begin
        if (wr_mask[i]) begin
          mem[wr_adr][8*i +: 8] <= din[8*i +: 8];
          par_mem[wr_adr][i]    <= wr_par[i];
        end
      end
    end
  end

  // Write wins over flush so the freshly written entry stays valid.
  always_ff @(posedge l2clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else begin
      if (flush) valid <= '0;
      if (wr_eff) valid[wr_adr] <= 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_par  = '0;
    rd_calc = '0;
    hit     = 1'b0;
    if (rd_in_rng) begin
      rd_data = mem[rd_adr];
      rd_par  = par_mem[rd_adr];
      hit     = valid[rd_adr] | byp;
    end
    for (int i = 0; i < MASKW; i++) begin
      if (byp && wr_mask[i]) begin
        rd_data[8*i +: 8] = din[8*i +: 8];
        rd_par[i]         = wr_par[i];
      end
      rd_calc[i] = ^rd_data[8*i +: 8];
    end
    s0_data = hit ? rd_data : '0;
    s0_miss = ~hit;
    s0_perr = hit ? (rd_par ^ rd_calc) : '0;
  end

  always_ff @(posedge l2clk or posedge reset) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
      s1_miss <= 1'b0;
      s1_perr <= '0;
    end else begin
      s1_vld <= rd_en;
      if (rd_en) begin
        s1_data <= s0_data;
        s1_miss <= s0_miss;
        s1_perr <= s0_perr;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] s2_data;
      logic             s2_vld;
      logic             s2_miss;
      logic [MASKW-1:0] s2_perr;

      always_ff @(posedge l2clk or posedge reset) begin
        if (reset) begin
          s2_vld  <= 1'b0;
          s2_data <= '0;
          s2_miss <= 1'b0;
          s2_perr <= '0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) begin
            s2_data <= s1_data;
            s2_miss <= s1_miss;
            s2_perr <= s1_perr;
          end
        end
      end

      assign dout      = s2_data;
      assign dout_vld  = s2_vld;
      assign dout_miss = s2_miss;
      assign dout_perr = s2_perr;
    end else begin : g_lat1
      assign dout      = s1_data;
      assign dout_vld  = s1_vld;
      assign dout_miss = s1_miss;
      assign dout_perr = s1_perr;
    end
  endgenerate

endmodule

// File: tb/tb_n2_com_dp_rf_param.sv
// tb/tb_n2_com_dp_rf_param.sv - scoreboard bench for n2_com_dp_rf_param at RD_LAT 1 and 2
module tb_n2_com_dp_rf_param;

  localparam int DEPTH = 24;
  localparam int WIDTH = 152;
  localparam int AW    = 5;
  localparam int MASKW = WIDTH / 8;
  localparam logic [MASKW-1:0] ALLM = '1;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             miss;
    logic [MASKW-1:0] perr;
    int               cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [AW-1:0]    wr_adr;
  logic [MASKW-1:0] wr_mask;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [AW-1:0]    rd_adr;
  logic             flush;
  logic             err_inject;
  logic             inhibit;

  logic [WIDTH-1:0] d1_dout, d2_dout;
  logic             d1_vld, d2_vld, d1_miss, d2_miss;
  logic [MASKW-1:0] d1_perr, d2_perr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  n2_com_dp_rf_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .MASKW(MASKW), .RD_LAT(1)) u_lat1 (
    .l2clk(clk), .reset(reset), .wr_en(wr_en), .wr_adr(wr_adr), .wr_mask(wr_mask), .din(din),
    .rd_en(rd_en), .rd_adr(rd_adr), .flush(flush), .err_inject(err_inject),
    .tcu_array_wr_inhibit(inhibit), .dout(d1_dout), .dout_vld(d1_vld), .dout_miss(d1_miss),
    .dout_perr(d1_perr)
  );

  n2_com_dp_rf_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .MASKW(MASKW), .RD_LAT(2)) u_lat2 (
    .l2clk(clk), .reset(reset), .wr_en(wr_en), .wr_adr(wr_adr), .wr_mask(wr_mask), .din(din),
    .rd_en(rd_en), .rd_adr(rd_adr), .flush(flush), .err_inject(err_inject),
    .tcu_array_wr_inhibit(inhibit), .dout(d2_dout), .dout_vld(d2_vld), .dout_miss(d2_miss),
    .dout_perr(d2_perr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [WIDTH-1:0] rep(input logic [7:0] b);
    logic [WIDTH-1:0] v;
    for (int i = 0; i < MASKW; i++) v[8*i +: 8] = b;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mon(input int lat, input logic [WIDTH-1:0] d, input logic m, input logic [MASKW-1:0] p);
    exp_t e;
    if ((lat == 1 && q1.size() == 0) || (lat == 2 && q2.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL lat%0d_unexpected_vld got vld=1 want no result at cycle %0d", lat, cyc);
    end else begin
      if (lat == 1) e = q1.pop_front();
      else          e = q2.pop_front();
      chk($sformatf("lat%0d_latency", lat), WIDTH'(cyc - e.cyc), WIDTH'(lat));
      chk($sformatf("lat%0d_dout", lat), d, e.data);
      chk($sformatf("lat%0d_miss", lat), WIDTH'(m), WIDTH'(e.miss));
      chk($sformatf("lat%0d_perr", lat), WIDTH'(p), WIDTH'(e.perr));
    end
  endtask

  always @(negedge clk) begin
    if (!reset && d1_vld) mon(1, d1_dout, d1_miss, d1_perr);
    if (!reset && d2_vld) mon(2, d2_dout, d2_miss, d2_perr);
  end

  task automatic idle();
    wr_en = 0; wr_adr = '0; wr_mask = '0; din = '0; err_inject = 0; inhibit = 0;
    rd_en = 0; rd_adr = '0; flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input int a, input logic [MASKW-1:0] m, input logic [WIDTH-1:0] d,
                    input logic inj, input logic inh);
    wr_en = 1; wr_adr = AW'(a); wr_mask = m; din = d; err_inject = inj; inhibit = inh;
  endtask

  task automatic rd_raw(input int a);
    rd_en = 1; rd_adr = AW'(a);
  endtask

  task automatic rd(input int a, input logic [WIDTH-1:0] ed, input logic em, input logic [MASKW-1:0] ep);
    exp_t e;
    rd_raw(a);
    e.data = ed; e.miss = em; e.perr = ep; e.cyc = cyc;
    q1.push_back(e);
    q2.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_d1_dout"}, d1_dout, '0);
    chk({tag, "_d1_ctl"}, WIDTH'({d1_vld, d1_miss, d1_perr}), '0);
    chk({tag, "_d2_dout"}, d2_dout, '0);
    chk({tag, "_d2_ctl"}, WIDTH'({d2_vld, d2_miss, d2_perr}), '0);
  endtask

  logic [WIDTH-1:0] ev;

  initial begin
    idle();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset_hold");
    reset = 0;
    step();
    chk_reset_outputs("reset_rel");

    // Fresh array: every entry reads as miss.
    rd(3, '0, 1, '0); step();

    // Masked overwrite of byte 0 only.
    wr(5, ALLM, rep(8'hA5), 0, 0); step();
    wr(5, 19'h00001, rep(8'h3C), 0, 0); step();
    ev = rep(8'hA5); ev[7:0] = 8'h3C;
    rd(5, ev, 0, '0); step();

    // Same-cycle bypass, then back-to-back reads.
    wr(7, ALLM, rep(8'hFF), 0, 0); rd(7, rep(8'hFF), 0, '0); step();
    rd(7, rep(8'hFF), 0, '0); step();
    rd(8, '0, 1, '0); step();
    rd(7, rep(8'hFF), 0, '0); step();
    step();
    chk("hold_vld_low", WIDTH'(d1_vld), '0);
    chk("hold_dout", d1_dout, rep(8'hFF));

    // Parity error injection and repair.
    wr(2, ALLM, rep(8'h5A), 1, 0); step();
    rd(2, rep(8'h5A), 0, 19'h00001); step();
    wr(2, ALLM, rep(8'h5A), 0, 0); step();
    rd(2, rep(8'h5A), 0, '0); step();
    wr(12, ALLM, rep(8'h5A), 1, 0); rd(12, rep(8'h5A), 0, 19'h00001); step();

    // Flush with concurrent write and read of a valid entry.
    wr(4, ALLM, rep(8'h11), 0, 0); step();
    flush = 1; wr(9, ALLM, rep(8'h22), 0, 0); rd(4, rep(8'h11), 0, '0); step();
    rd(4, '0, 1, '0); step();
    rd(9, rep(8'h22), 0, '0); step();
    rd(5, '0, 1, '0); step();

    // Partial bypass onto a flushed entry keeps stale unmasked bytes.
    ev = rep(8'hA5); ev[7:0] = 8'h3C; ev[15:8] = 8'h77;
    wr(5, 19'h00002, rep(8'h77), 0, 0); rd(5, ev, 0, '0); step();

    // Inhibited writes: no state change, no bypass.
    wr(10, ALLM, rep(8'h99), 0, 1); step();
    rd(10, '0, 1, '0); step();
    wr(11, ALLM, rep(8'h99), 0, 1); rd(11, '0, 1, '0); step();

    // Address range boundary.
    wr(DEPTH-1, ALLM, rep(8'h44), 0, 0); step();
    rd(DEPTH-1, rep(8'h44), 0, '0); step();
    wr(DEPTH+1, ALLM, rep(8'h55), 0, 0); rd(DEPTH+1, '0, 1, '0); step();
    repeat (3) step();

    // Reset while a read is in flight: its result must never appear.
    wr(6, ALLM, rep(8'h66), 0, 0); step();
    rd_raw(6); step();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset_mid");
    reset = 0;
    repeat (3) step();
    rd(6, '0, 1, '0); step();
    rd(9, '0, 1, '0); step();

    repeat (4) step();
    chk("q1_drained", WIDTH'(q1.size()), '0);
    chk("q2_drained", WIDTH'(q2.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
